// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state codes, lamp encodings and state-to-lamp mapping
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Returns {ns_light, ew_light}
    function automatic logic [5:0] lamps(state_t s);
        return s == NS_GREEN  ? {GREEN, RED}  :
               s == NS_YELLOW ? {YELLOW, RED} :
               s == EW_GREEN  ? {RED, GREEN}  :
               s == EW_YELLOW ? {RED, YELLOW} : {RED, RED};
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that stops at zero and flags expiry on a tick
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - CNT_W'(1);

    assign expired = tick && count == '0;

endmodule

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: NS/EW intersection sequencer with pedestrian walk phase
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       ew_car,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    // Timer value seen on the WALK_TICKS-th tick of EW green
    localparam logic [CNT_W-1:0] WALK_END  = CNT_W'(GREEN_TICKS - WALK_TICKS);

    state_t           state, state_d;
    logic [CNT_W-1:0] count, load_val;
    logic             expired, load, walk_d;

    phase_timer #(.CNT_W(CNT_W), .RST_VAL(GREEN_LD)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .count    (count),
        .expired  (expired)
    );

    always_comb begin
        state_d  = state > ALLRED_B ? ALLRED_B :
                   !expired || (state == NS_GREEN && !ew_car && !ped_pending) ? state :
                   state == ALLRED_B ? NS_GREEN : state_t'(state + 3'd1);
        load     = state_d != state;
        load_val = state_d == NS_GREEN  || state_d == EW_GREEN  ? GREEN_LD  :
                   state_d == NS_YELLOW || state_d == EW_YELLOW ? YELLOW_LD : ALLRED_LD;
        walk_d   = state_d != EW_GREEN ? 1'b0 :
                   state != EW_GREEN   ? ped_pending :
                   ped_walk && !(tick && count == WALK_END);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state       <= NS_GREEN;
            ped_pending <= 1'b0;
            ped_walk    <= 1'b0;
        end else begin
            state       <= state_d;
            ped_pending <= ped_req || (ped_pending && !(state != EW_GREEN && state_d == EW_GREEN));
            ped_walk    <= walk_d;
        end

    assign {ns_light, ew_light} = lamps(state);
    assign phase                = state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: randomized scoreboard bench against a tick-counting phase model
module tb_traffic_light_controller;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic [2:0] ph;
        logic       walk;
        logic       pend;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } ent_t;

    typedef struct {
        int   p;
        int   e;
        logic pend;
        logic grant;
    } mdl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic ped_req = 1'b0;
    logic ew_car = 1'b0;
    logic [2:0] ns_light, ew_light, phase, ns2, ew2, phase2;
    logic ped_walk, ped_pending, walk2, pend2;

    int checks = 0;
    int failures = 0;
    ent_t exp_q[$];
    mdl_t m1, m2;

    int D1[6] = '{20, 4, 2, 20, 4, 2};
    int D2[6] = '{1, 1, 1, 1, 1, 1};
    logic [2:0] NS_TAB[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] EW_TAB[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    traffic_light_controller dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .ped_req     (ped_req),
        .ew_car      (ew_car),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .ped_walk    (ped_walk),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    traffic_light_controller #(
        .GREEN_TICKS(1), .YELLOW_TICKS(1), .ALLRED_TICKS(1), .WALK_TICKS(1)
    ) dut_fast (
        .clk         (clk),
        .reset       (reset),
        .tick        (1'b1),
        .ped_req     (1'b1),
        .ew_car      (1'b1),
        .ns_light    (ns2),
        .ew_light    (ew2),
        .ped_walk    (walk2),
        .ped_pending (pend2),
        .phase       (phase2)
    );

    always #5 clk = ~clk;

    // Phase index plus ticks elapsed since entry; a phase ends once its tick count is used up
    function automatic void step(inout mdl_t m, input int d[6], input logic t, input logic car, input logic req);
        logic adv, enter;
        adv   = t && m.e >= d[m.p] - 1 && (m.p != 0 || car || m.pend);
        enter = adv && m.p == 2;
        if (adv) begin
            m.p = (m.p + 1) % 6;
            m.e = 0;
        end else if (t)
            m.e++;
        if (enter)
            m.grant = m.pend;
        m.pend = req || (m.pend && !enter);
    endfunction

    function automatic obs_t obs(mdl_t m, int w);
        obs_t o;
        o.ns   = NS_TAB[m.p];
        o.ew   = EW_TAB[m.p];
        o.ph   = 3'(m.p);
        o.walk = m.p == 3 && m.grant && m.e < w;
        o.pend = m.pend;
        return o;
    endfunction

    task automatic push_exp();
        ent_t e;
        e.a = obs(m1, 10);
        e.b = obs(m2, 1);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic t, input logic car, input logic req);
        @(negedge clk);
        reset   = 1'b1;
        tick    = t;
        ew_car  = car;
        ped_req = req;
        step(m1, D1, t, car, req);
        step(m2, D2, 1'b1, 1'b1, 1'b1);
        push_exp();
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #3;
        exp_q.delete();
        m1 = '{0, 0, 1'b0, 1'b0};
        m2 = '{0, 0, 1'b0, 1'b0};
        push_exp();
        reset = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            push_exp();
        end
    endtask

    initial begin
        ent_t e;
        obs_t g1, g2;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                g1 = {ns_light, ew_light, phase, ped_walk, ped_pending};
                g2 = {ns2, ew2, phase2, walk2, pend2};
                checks++;
                if (g1 !== e.a) begin
                    failures++;
                    $display("FAIL main t=%0t got ns=%b ew=%b ph=%0d walk=%b pend=%b exp ns=%b ew=%b ph=%0d walk=%b pend=%b",
                             $time, g1.ns, g1.ew, g1.ph, g1.walk, g1.pend, e.a.ns, e.a.ew, e.a.ph, e.a.walk, e.a.pend);
                end
                checks++;
                if (g2 !== e.b) begin
                    failures++;
                    $display("FAIL fast t=%0t got ns=%b ew=%b ph=%0d walk=%b pend=%b exp ns=%b ew=%b ph=%0d walk=%b pend=%b",
                             $time, g2.ns, g2.ew, g2.ph, g2.walk, g2.pend, e.b.ns, e.b.ew, e.b.ph, e.b.walk, e.b.pend);
                end
            end
        end
    end

    initial begin
        logic car, req;
        bit   hit;
        do_reset(3);
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 1) == 1, 1'b0, 1'b0);
        car = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0)
                car = !car;
            req = $urandom_range(0, 39) == 0;
            cycle($urandom_range(0, 1) == 1, car, req);
        end
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            cycle($urandom_range(0, 1) == 1, 1'b1, 1'b0);
            hit = m1.p == 4 && m1.e >= 2;
        end
        if (!hit) begin
            $display("FAIL ew_yellow_wait: model never reached EW_YELLOW tick 3 within 2000 cycles");
            $fatal(1, "wait bound expired");
        end
        do_reset(2);
        for (int i = 0; i < 200; i++)
            cycle(1'b1, 1'b1, $urandom_range(0, 29) == 0);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 29) == 0)
                car = !car;
            req = $urandom_range(0, 19) == 0 ? 1'b1 : req && $urandom_range(0, 2) != 0;
            cycle($urandom_range(0, 2) != 0, car, req);
        end
        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
